// File: rtl/cordic_req_sched.sv
// cordic_req_sched: round-robin arbiter that shares one iterative CORDIC core among N_REQ requesters
module cordic_req_sched #(
  parameter int N_REQ = 4,
  parameter int W = 17,
  parameter int TIMEOUT = 16,
  parameter int K_INIT = 19898,
  localparam int ID_W = (N_REQ > 2) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  output logic [N_REQ-1:0]   req_ready,
  input  logic [N_REQ-1:0]   req_mode,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic               core_start,
  output logic               core_mode,
  output logic [W-1:0]       core_x,
  output logic [W-1:0]       core_y,
  output logic [W-1:0]       core_z,
  output logic               core_abort,
  input  logic               core_done,
  input  logic [W-1:0]       core_out1,
  input  logic [W-1:0]       core_out2,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [ID_W-1:0]    resp_id,
  output logic [W-1:0]       resp_out1,
  output logic [W-1:0]       resp_out2,
  output logic               resp_err,
  output logic               stray_done
);
  localparam int TW = $clog2(TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, gnt;
  logic [ID_W:0] idx;
  logic any;
  logic [TW-1:0] timer;
  logic timeout;
  logic [W-1:0] sel_a, sel_b;
  // scan farthest-first so the requester nearest to rr_ptr overwrites the others
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(k);
      idx = idx >= (ID_W+1)'(N_REQ) ? idx - (ID_W+1)'(N_REQ) : idx;
      if (req_valid[idx[ID_W-1:0]]) begin
        gnt = idx[ID_W-1:0];
        any = 1'b1;
      end
    end
  end
  assign sel_a = req_a[gnt*W +: W];
  assign sel_b = req_b[gnt*W +: W];
  // abort lands on the last allowed WAIT cycle, i.e. TIMEOUT-1 cycles after core_start
  assign timeout = timer == TW'(TIMEOUT - 2) && !core_done;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = any ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (core_done || timeout) ? RESP : WAIT;
      RESP:    state_nx = resp_ready ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    req_ready  = (state == IDLE && any) ? N_REQ'(1) << gnt : '0;
    core_start = state == ISSUE;
    core_abort = state == WAIT && timeout;
    resp_valid = state == RESP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      timer      <= '0;
      resp_id    <= '0;
      core_mode  <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
      core_z     <= '0;
      resp_out1  <= '0;
      resp_out2  <= '0;
      resp_err   <= 1'b0;
      stray_done <= 1'b0;
    end else begin
      if (state == IDLE && any) begin
        resp_id   <= gnt;
        core_mode <= req_mode[gnt];
        core_x    <= req_mode[gnt] ? sel_a : W'(K_INIT);
        core_y    <= req_mode[gnt] ? sel_b : '0;
        core_z    <= req_mode[gnt] ? '0 : sel_a;
      end
      timer <= state == ISSUE ? '0 : (state == WAIT && !core_done) ? timer + 1'b1 : timer;
      if (state == WAIT && (core_done || timeout)) begin
        resp_out1 <= core_done ? core_out1 : '0;
        resp_out2 <= core_done ? core_out2 : '0;
        resp_err  <= !core_done;
      end
      if (state == RESP && resp_ready) rr_ptr <= resp_id == ID_W'(N_REQ - 1) ? '0 : resp_id + 1'b1;
      if (core_done && state != WAIT) stray_done <= 1'b1;
    end
  end
endmodule
